// File: rtl/shift_sched_if.sv
// Requester and shared-shifter bus for shift_sched.
// The slave modport is the scheduler; the master side holds the requesters and the shifter.
interface shift_sched_if #(
    parameter int N_CH    = 4,
    parameter int SHIFT_W = 5
);
    logic [N_CH-1:0]    req;
    logic [N_CH*40-1:0] data;
    logic [N_CH-1:0]    ack;
    logic               sh_en;
    logic [SHIFT_W-1:0] sh_shift;
    logic [39:0]        sh_in;
    logic [15:0]        sh_out;

    modport master (
        output req, data, sh_out,
        input  ack, sh_en, sh_shift, sh_in
    );

    modport slave (
        input  req, data, sh_out,
        output ack, sh_en, sh_shift, sh_in
    );
endinterface

// File: rtl/shift_sched.sv
// Round-robin scheduler of N_CH 40-bit accumulators onto one shared 40->16 shifter.
// Define SHIFT_SCHED_AUTO_EN to pick the shift per grant automatically instead of from cfg registers.
module shift_sched #(
    parameter int N_CH    = 4,
    parameter int SHIFT_W = 5
) (
    input  logic                    ck,
    input  logic                    rst_n,
    shift_sched_if.slave            bus,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    clr,
    output logic                    out_valid,
    output logic [15:0]             out_data,
    output logic [$clog2(N_CH)-1:0] out_ch,
    output logic [SHIFT_W-1:0]      out_shift,
    output logic [N_CH-1:0]         clip
);
    localparam int CW = $clog2(N_CH);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(24);

    logic [CW-1:0]      ptr;
    logic [CW-1:0]      gnt_idx;
    logic               gnt_any;
    logic [39:0]        gnt_data;
    logic [SHIFT_W-1:0] gnt_shift;
    logic               gnt_clip;
    logic [N_CH-1:0]    gnt_onehot;
    logic [CW-1:0]      sh_ch;
    logic               res_valid;
    logic [15:0]        data_hold;

    // True when bits [39:15+s] are all equal, i.e. the value survives a shift by s into 16-bit signed.
    function automatic logic fits(input logic [39:0] v, input int s);
        logic signed [39:0] t;
        t = $signed(v) >>> (15 + s);
        return (t == '0) || (&t);
    endfunction

    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = ptr;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!gnt_any && bus.req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
    end

    assign gnt_data   = bus.data[int'(gnt_idx)*40 +: 40];
    assign gnt_onehot = N_CH'(1) << gnt_idx;

`ifdef SHIFT_SCHED_AUTO_EN
    logic auto_fit;
    logic unused_cfg;
    assign unused_cfg = ^{cfg_we, cfg_ch, cfg_shift};

    // Walk downward so the last fitting shift found is the smallest one.
    always_comb begin
        gnt_shift = MAX_SHIFT;
        auto_fit  = 1'b0;
        for (int s = 24; s >= 0; s--) begin
            if (fits(gnt_data, s)) begin
                gnt_shift = SHIFT_W'(s);
                auto_fit  = 1'b1;
            end
        end
        gnt_clip = !auto_fit;
    end
`else
    logic [SHIFT_W-1:0] shift_reg [N_CH];

    // Registered write: a grant in the same cycle still reads the old value.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) shift_reg[i] <= '0;
        end else if (cfg_we && (int'(cfg_ch) < N_CH)) begin
            shift_reg[cfg_ch] <= (cfg_shift > MAX_SHIFT) ? MAX_SHIFT : cfg_shift;
        end
    end

    always_comb begin
        gnt_shift = shift_reg[gnt_idx];
        gnt_clip  = !fits(gnt_data, int'(shift_reg[gnt_idx]));
    end
`endif

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= CW'(N_CH - 1);
            bus.ack      <= '0;
            bus.sh_en    <= 1'b0;
            bus.sh_shift <= '0;
            bus.sh_in    <= '0;
            sh_ch        <= '0;
            clip         <= '0;
        end else begin
            clip <= (clr ? '0 : clip) | ((gnt_any && gnt_clip) ? gnt_onehot : '0);
            if (gnt_any) begin
                ptr          <= gnt_idx;
                bus.ack      <= gnt_onehot;
                bus.sh_en    <= 1'b1;
                bus.sh_shift <= gnt_shift;
                bus.sh_in    <= gnt_data;
                sh_ch        <= gnt_idx;
            end else begin
                bus.ack      <= '0;
                bus.sh_en    <= 1'b0;
                bus.sh_shift <= '0;
                bus.sh_in    <= '0;
            end
        end
    end

    // The shifter registers sh_out on the same edge that loads res_valid, so out_data passes it through.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            out_ch    <= '0;
            out_shift <= '0;
            data_hold <= '0;
        end else begin
            res_valid <= bus.sh_en;
            if (bus.sh_en) begin
                out_ch    <= sh_ch;
                out_shift <= bus.sh_shift;
            end
            if (res_valid) data_hold <= bus.sh_out;
        end
    end

    assign out_valid = res_valid;
    assign out_data  = res_valid ? bus.sh_out : data_hold;
endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter N_CH, default 4: number of requesters sharing one shifter; 2..8.
REQ-002 Parameter SHIFT_W, default 5: width of shift fields; matches the shifter's SHIFT_W.
REQ-003 ck  in  1  sole clock; all logic on posedge ck.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  N_CH  per-channel request; held high with data stable until ack.
REQ-006 data  in  N_CH*40  per-channel 40-bit signed accumulator, channel c at bits [40c+39:40c].
REQ-007 ack  out  N_CH  one-cycle pulse: channel's data accepted this cycle.
REQ-008 cfg_we, cfg_ch, cfg_shift  in  1, clog2(N_CH), SHIFT_W  per-channel shift register write.
REQ-009 clr  in  1  clears all clip flags.
REQ-010 sh_en, sh_shift, sh_in  out  1, SHIFT_W, 40  registered drive to the shared shifter.
REQ-011 sh_out  in  16  shifter result, registered one edge after sh_en.
REQ-012 out_valid, out_data, out_ch, out_shift  out  1, 16, clog2(N_CH), SHIFT_W  result strobe, value, source channel, shift used.
REQ-013 clip  out  N_CH  sticky per-channel flag: significant high bits discarded.

Function
REQ-014 Arbitration: round-robin; search starts at last granted channel + 1, wraps N_CH-1 -> 0.
REQ-015 At most one grant per cycle; a grant registers sh_en=1, sh_shift, sh_in=data of granted channel, and pulses ack for that channel in the same registered cycle.
REQ-016 No request pending: sh_en=0, sh_in=0, sh_shift=0.
REQ-017 Latency: grant edge E0 -> shifter captures at E1 -> out_valid=1 with out_data=sh_out during the cycle after E1; fully pipelined, one result per cycle sustained.
REQ-018 out_ch and out_shift delayed one stage to align with sh_out; out_valid=0 keeps out_data/out_ch/out_shift at last values.
REQ-019 Per-channel shift registers reset to 0; cfg_shift > 24 written as 24.
REQ-020 cfg write and grant to same channel in same cycle: grant uses old shift; new value effective next cycle.
REQ-021 Clip detect at grant: in[39:15+s] not all equal -> set clip[c] at E0+1.
REQ-022 clr and clip set in same cycle: set wins.
REQ-023 Requester deasserting req without ack: no grant, no result; req held after ack is re-granted at its next round-robin turn.

Reset
REQ-024 rst_n low: ack, sh_en, out_valid, clip = 0; sh_shift, sh_in, out_data, out_ch, out_shift = 0; RR pointer = N_CH-1 (channel 0 first); shift registers = 0.
REQ-025 Reset mid-operation discards in-flight results; no out_valid produced for them after release.

Configuration
REQ-026 Macro SHIFT_SCHED_AUTO_EN defined: shift per grant = smallest s in 0..24 with in[39:15+s] all equal (value fits 16-bit signed), else 24 with clip set; cfg_we ignored, shift registers unused.
REQ-027 Macro SHIFT_SCHED_AUTO_EN undefined: shift per grant = channel's configured shift register.
REQ-028 out_shift reports the shift actually applied in both builds.

Verification
REQ-029 Reset release, req=0001, data0=0x00_0000_1234, shift0=0 -> ack[0] pulse, 2 edges later out_valid, out_data=0x1234, out_ch=0.
REQ-030 req=1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3, one ack per cycle, 8 consecutive out_valid.
REQ-031 Manual: shift1=8, data1=0x00_0012_3400 -> out_data=0x1234, clip[1]=0; data1=0x01_0000_0000 -> clip[1]=1, held until clr.
REQ-032 cfg_shift=31 to ch2 -> out_shift=24; cfg write to ch2 same cycle as its grant -> old shift used.
REQ-033 AUTO_EN: data=0xFF_FFFF_8000 -> out_shift=0, out_data=0x8000; data=0x00_0001_0000 -> out_shift=2, out_data=0x4000.
REQ-034 rst_n low one cycle after grant -> no out_valid after release, clip cleared, next grant to channel 0.
